scroll_ctrl: RTL and testbench

Sequencer for the 3-digit seven-segment scrolling display path. Accepts a message of BCD/hex nibbles through a valid/ready load port and stores it in an internal buffer. On start, it steps a DIGITS-wide window across the message at a programmable tick rate, padding both ends with blank codes. Drives the packed nibble bus that feeds the seven-segment decoders.

---
 rtl/scroll_pkg.sv | 27 ++
 rtl/scroll_tick_gen.sv | 43 ++++
 rtl/scroll_ctrl.sv | 169 ++++++++++++++++
 tb/tb_scroll_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : scroll_pkg                                                   |
// | Purpose : Shared definitions for the scrolling seven-segment path:     |
// |           blank digit code, sequencer state encoding and the width     |
// |           helper for the frame counter.                                |
// | Ports   : none (package)                                               |
// | Rev     : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package scroll_pkg;

  // Nibble code the seven-segment decoder renders as an unlit digit.
  localparam logic [3:0] c_blk = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Frames run 0..msg_max+digits, so the counter must hold msg_max+digits.
  function automatic int frame_w(input int msg_max, input int digits);
    return $clog2(msg_max + digits + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scroll_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : scroll_tick_gen                                              |
// | Purpose : Prescaler for the scroll rate. Counts 0..TICK_DIV-1 while    |
// |           enabled and flags the terminal count with a one-cycle tick.  |
// | Ports   : clk    - clock, rising edge                                  |
// |           rst    - asynchronous active-low reset                       |
// |           i_en   - count enable; counter is held at 0 when low         |
// |           i_clr  - synchronous clear back to 0                         |
// |           o_tick - high during the terminal-count cycle                |
// | Rev     : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module scroll_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW     = $clog2(TICK_DIV);
  localparam logic [CW-1:0] c_last = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/scroll_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : scroll_ctrl                                                  |
// | Purpose : Scrolling-display sequencer. Buffers a nibble message from a |
// |           valid/ready port, then slides a DIGITS-wide window across it |
// |           (blank-padded at both ends) at one step per TICK_DIV clocks. |
// | Ports   : clk, rst (async active-low)                                  |
// |           din/din_valid/din_ready - message load port (IDLE only)      |
// |           msg_clr  - empty the buffer (IDLE only, beats a write)       |
// |           i_start  - begin a pass, i_stop - abort a pass               |
// |           o_win    - packed window, leftmost digit in the MSBs         |
// |           o_busy   - scrolling, o_done - one-cycle end-of-pass pulse   |
// |           o_frame  - current frame index                              |
// | Config  : SCROLL_LOOP_EN - wrap to frame 0 after the last frame and    |
// |           keep scrolling until i_stop; o_done is then tied low.        |
// | Rev     : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int         DIGITS   = 3,
  parameter int         MSG_MAX  = 8,
  parameter int         TICK_DIV = 25000000,
  parameter logic [3:0] BLK      = c_blk
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [3:0]                           din,
  input  logic                                 din_valid,
  output logic                                 din_ready,
  input  logic                                 msg_clr,
  input  logic                                 i_start,
  input  logic                                 i_stop,
  output logic [4*DIGITS-1:0]                  o_win,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic [frame_w(MSG_MAX, DIGITS)-1:0]  o_frame
);

  localparam int                  FW      = frame_w(MSG_MAX, DIGITS);
  localparam int                  LW      = $clog2(MSG_MAX + 1);
  localparam int                  IW      = (MSG_MAX > 1) ? $clog2(MSG_MAX) : 1;
  localparam logic [FW:0]         c_dig_x = (FW+1)'(DIGITS);
  localparam logic [FW-1:0]       c_dig_f = FW'(DIGITS);
  localparam logic [LW-1:0]       c_max   = LW'(MSG_MAX);
  localparam logic [4*DIGITS-1:0] c_blank = {DIGITS{BLK}};

  state_t              r_state;
  logic [LW-1:0]       r_len;
  logic [3:0]          r_msg [MSG_MAX];
  logic [FW-1:0]       r_frame;
  logic [4*DIGITS-1:0] r_win;
  logic [4*DIGITS-1:0] w_win;
  logic                r_busy;
  logic                w_tick;
  logic                w_last;

  assign din_ready = (r_state == IDLE) && (r_len < c_max);
  assign o_win     = r_win;
  assign o_busy    = r_busy;
  assign o_frame   = r_frame;
  assign w_last    = (r_frame == (FW'(r_len) + c_dig_f));

`ifdef SCROLL_LOOP_EN
  assign o_done = 1'b0;
`else
  logic r_done;
  assign o_done = r_done;
`endif

  scroll_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state == SCROLL),
    .i_clr  (i_stop),
    .o_tick (w_tick)
  );

  // Slot j shows message position frame+j-DIGITS. The sum frame+j is kept
  // one bit wider than the frame so it never wraps; positions left of the
  // message (sum < DIGITS) or past its end resolve to the blank code.
  for (genvar j = 0; j < DIGITS; j++) begin : g_slot
    logic [FW:0] w_pos;
    logic [FW:0] w_idx;
    assign w_pos = {1'b0, r_frame} + (FW+1)'(j);
    assign w_idx = w_pos - c_dig_x;
    assign w_win[4*(DIGITS-1-j) +: 4] =
      ((w_pos >= c_dig_x) && (w_idx < (FW+1)'(r_len))) ? r_msg[w_idx[IW-1:0]] : BLK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_frame <= '0;
      r_win   <= c_blank;
      r_busy  <= 1'b0;
`ifdef SCROLL_LOOP_EN
`else
      r_done  <= 1'b0;
`endif
      for (int k = 0; k < MSG_MAX; k++) begin
        r_msg[k] <= '0;
      end
    end else begin
`ifdef SCROLL_LOOP_EN
`else
      r_done <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_win   <= c_blank;
          r_frame <= '0;
          if (msg_clr) begin
            r_len <= '0;
          end else if (din_valid && din_ready) begin
            r_msg[r_len[IW-1:0]] <= din;
            r_len                <= r_len + 1'b1;
          end
          // A same-cycle clear empties the buffer, so it also blocks a start.
          if (i_start && !msg_clr && (r_len != '0)) begin
            r_state <= SCROLL;
            r_busy  <= 1'b1;
          end
        end

        SCROLL: begin
          if (i_stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_frame <= '0;
            r_win   <= c_blank;
          end else begin
            // Window register trails the frame counter by one cycle.
            r_win <= w_win;
            if (w_tick) begin
              if (w_last) begin
                r_frame <= '0;
`ifdef SCROLL_LOOP_EN
`else
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
`endif
              end else begin
                r_frame <= r_frame + 1'b1;
              end
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_win   <= c_blank;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_win   <= c_blank;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scroll_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_scroll_ctrl                                               |
// | Purpose : Scoreboard bench for scroll_ctrl (DIGITS=3, MSG_MAX=8,       |
// |           TICK_DIV=4). Stimulus queues the expected window/frame for   |
// |           every busy cycle; a negedge monitor pops and compares.       |
// | Ports   : none                                                         |
// | Rev     : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_scroll_ctrl;

  localparam int DIGITS   = 3;
  localparam int MSG_MAX  = 8;
  localparam int TICK_DIV = 4;
  localparam int FW       = $clog2(MSG_MAX + DIGITS + 1);

  // Hand-computed frame tables, first frame in the most significant slot.
  localparam logic [191:0] T_123 = 192'({12'hFFF, 12'hFF1, 12'hF12, 12'h123,
                                         12'h23F, 12'h3FF, 12'hFFF});
  localparam logic [191:0] T_0_7 = 192'({12'hFFF, 12'hFF0, 12'hF01, 12'h012,
                                         12'h123, 12'h234, 12'h345, 12'h456,
                                         12'h567, 12'h67F, 12'h7FF, 12'hFFF});
  localparam logic [191:0] T_12  = 192'({12'hFFF, 12'hFF1, 12'hF12, 12'h12F,
                                         12'h2FF, 12'hFFF});

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    din = 4'h0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          msg_clr = 1'b0;
  logic          i_start = 1'b0;
  logic          i_stop  = 1'b0;
  logic [11:0]   o_win;
  logic          o_busy;
  logic          o_done;
  logic [FW-1:0] o_frame;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [11:0]   win;
    logic [FW-1:0] frame;
  } exp_t;

  exp_t sb[$];
  int   done_q[$];
  exp_t mon_e;

  scroll_ctrl #(
    .DIGITS   (DIGITS),
    .MSG_MAX  (MSG_MAX),
    .TICK_DIV (TICK_DIV),
    .BLK      (4'hF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .msg_clr   (msg_clr),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .o_win     (o_win),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_frame   (o_frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Busy cycle k (counted from the cycle the DUT enters SCROLL) shows frame
  // k/TICK_DIV on o_frame, while o_win lags one cycle behind it.
  task automatic expect_seq(input logic [191:0] tbl, input int nf, input int nsamp,
                            input bit with_done);
    for (int k = 0; k < nsamp; k++) begin
      exp_t e;
      int   fi;
      e.frame = FW'((k / TICK_DIV) % nf);
      if (k == 0) begin
        e.win = 12'hFFF;
      end else begin
        fi    = ((k - 1) / TICK_DIV) % nf;
        e.win = tbl[(nf-1-fi)*12 +: 12];
      end
      sb.push_back(e);
    end
    if (with_done) done_q.push_back(1);
  endtask

  always @(negedge clk) begin
    if (o_busy) begin
      if (sb.size() == 0) begin
        chk("unexpected_busy", 32'(o_busy), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("win", 32'(o_win), 32'(mon_e.win));
        chk("frame", 32'(o_frame), 32'(mon_e.frame));
      end
    end
    if (o_done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 32'(o_done), 32'(0));
      end else begin
        void'(done_q.pop_front());
        chk("busy_at_done", 32'(o_busy), 32'(0));
      end
    end
  end

  task automatic load_nib(input logic [3:0] v);
    din       = v;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic stop_after(input int edges);
    repeat (edges) @(posedge clk);
    #1 i_stop = 1'b1;
    @(posedge clk); #1;
    i_stop = 1'b0;
    @(negedge clk);
    chk("stop_win", 32'(o_win), 32'hFFF);
    chk("stop_frame", 32'(o_frame), 32'(0));
    chk("stop_busy", 32'(o_busy), 32'(0));
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while ((sb.size() != 0 || done_q.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(sb.size() + done_q.size()), 32'(0));
    @(negedge clk);
    chk("idle_busy", 32'(o_busy), 32'(0));
    chk("idle_done", 32'(o_done), 32'(0));
    chk("idle_win", 32'(o_win), 32'hFFF);
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_win", 32'(o_win), 32'hFFF);
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_done", 32'(o_done), 32'(0));
    chk("rst_frame", 32'(o_frame), 32'(0));
    chk("rst_ready", 32'(din_ready), 32'(1));
    @(posedge clk); #1 rst = 1'b1;

`ifdef SCROLL_LOOP_EN
    // Looping pass: two full laps plus the first two cycles of a third.
    load_nib(4'h1);
    load_nib(4'h2);
    expect_seq(T_12, 6, 50, 1'b0);
    pulse_start();
    stop_after(49);
    wait_drain(20);
`else
    // Plain pass over 1,2,3.
    load_nib(4'h1);
    load_nib(4'h2);
    load_nib(4'h3);
    expect_seq(T_123, 7, 28, 1'b1);
    pulse_start();
    wait_drain(60);

    // Fill to capacity; the ninth nibble must be dropped.
    msg_clr = 1'b1;
    @(posedge clk); #1 msg_clr = 1'b0;
    for (int i = 0; i < 8; i++) load_nib(4'(i));
    @(negedge clk);
    chk("full_ready", 32'(din_ready), 32'(0));
    load_nib(4'h9);
    expect_seq(T_0_7, 12, 48, 1'b1);
    pulse_start();
    wait_drain(80);

    // Clear beats a same-cycle write; start on an empty buffer is ignored.
    msg_clr   = 1'b1;
    din       = 4'h5;
    din_valid = 1'b1;
    @(posedge clk); #1;
    msg_clr   = 1'b0;
    din_valid = 1'b0;
    pulse_start();
    repeat (3) @(negedge clk);
    chk("empty_busy", 32'(o_busy), 32'(0));
    chk("empty_win", 32'(o_win), 32'hFFF);
    chk("empty_ready", 32'(din_ready), 32'(1));

    // Abort during frame 3, then replay the whole message.
    load_nib(4'h1);
    load_nib(4'h2);
    load_nib(4'h3);
    expect_seq(T_123, 7, 14, 1'b0);
    pulse_start();
    stop_after(13);
    chk("stop_drained", 32'(sb.size()), 32'(0));
    @(negedge clk);
    expect_seq(T_123, 7, 28, 1'b1);
    pulse_start();
    wait_drain(60);

    // Asynchronous reset between edges in the middle of a pass.
    expect_seq(T_123, 7, 9, 1'b0);
    pulse_start();
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_win", 32'(o_win), 32'hFFF);
    chk("arst_busy", 32'(o_busy), 32'(0));
    chk("arst_frame", 32'(o_frame), 32'(0));
    chk("arst_ready", 32'(din_ready), 32'(1));
    @(posedge clk); #1 rst = 1'b1;
    chk("arst_drained", 32'(sb.size()), 32'(0));
    pulse_start();
    repeat (3) @(negedge clk);
    chk("arst_len0_busy", 32'(o_busy), 32'(0));
`endif

    repeat (2) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'(0));
    chk("final_done_empty", 32'(done_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
